// File: rtl/aes_pkg.sv
// Shared AES constants: key-size encodings, Nk/Nr lookups, rcon/xtime helpers,
// expander FSM states and the forward S-box table.
package aes_pkg;

  localparam logic [1:0] KS_128  = 2'd0;
  localparam logic [1:0] KS_192  = 2'd1;
  localparam logic [1:0] KS_256  = 2'd2;
  localparam logic [1:0] KS_RSVD = 2'd3;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd4;
      KS_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_128:  return 4'd10;
      KS_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Entry x lives at SBOX[x]; index 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational S-box byte lookups.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = SBOX[i_word[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_expander_stream.sv
// Iterative AES-128/192/256 key schedule, one word per cycle, streaming 128-bit round keys.
// Optional round-key register file enabled by defining AES_ROUNDKEY_STORE_EN.
module aes_key_expander_stream
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS    = 256,
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  input  logic [1:0]              key_size,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic                    abort,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic                    busy,
  output logic                    key_err,
  input  logic [3:0]              rd_idx,
  output logic [127:0]            rd_data
);

  if (WORDS_PER_CYCLE != 1) begin : g_wpc_chk
    $error("aes_key_expander_stream: WORDS_PER_CYCLE must be 1");
  end
  if (MAX_KEY_BITS != 128 && MAX_KEY_BITS != 192 && MAX_KEY_BITS != 256) begin : g_mkb_chk
    $error("aes_key_expander_stream: MAX_KEY_BITS must be 128, 192 or 256");
  end

  state_t                  r_state;
  logic [MAX_KEY_BITS-1:0] r_key;
  logic [3:0]              r_nk;
  logic [2:0]              r_nkm1;
  logic [3:0]              r_nr;
  logic [5:0]              r_i;
  logic [2:0]              r_j;
  logic [7:0]              r_rcon;
  logic [7:0][31:0]        r_win;
  logic [95:0]             r_acc;
  logic [1:0]              r_acnt;
  logic [3:0]              r_rnd;
  logic [127:0]            r_rk_data;
  logic [3:0]              r_rk_idx;
  logic                    r_rk_last;
  logic                    r_rk_valid;
  logic                    r_key_ready;
  logic                    r_busy;
  logic                    r_key_err;

  logic        w_ks_ok;
  logic        w_load;
  logic        w_key_phase;
  logic        w_stall;
  logic        w_gen;
  logic        w_xfer;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_sbox_in;
  logic [31:0] w_sub;
  logic [31:0] w_word;

  always_comb begin
    w_ks_ok = 1'b1;
    case (key_size)
      KS_192:  w_ks_ok = (MAX_KEY_BITS >= 192);
      KS_256:  w_ks_ok = (MAX_KEY_BITS >= 256);
      KS_RSVD: w_ks_ok = 1'b0;
      default: w_ks_ok = 1'b1;
    endcase
  end

  assign w_load      = (r_state == ST_IDLE) && key_valid && !abort && w_ks_ok;
  assign w_key_phase = (r_i < {2'b00, r_nk});
  // The 4th word of a round needs the output register; hold it while the sink is stalled.
  assign w_stall     = (r_acnt == 2'd3) && r_rk_valid && !rk_ready;
  assign w_gen       = (r_state == ST_EXPAND) && !w_stall;
  assign w_xfer      = w_gen && (r_acnt == 2'd3);

  assign w_prev    = r_win[0];
  assign w_back    = r_win[r_nkm1];
  assign w_sbox_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sbox_word u_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sub)
  );

  always_comb begin
    w_word = w_back ^ w_prev;
    if (w_key_phase)
      w_word = r_key[MAX_KEY_BITS-1 -: 32];
    else if (r_j == 3'd0)
      w_word = w_back ^ w_sub ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_j == 3'd4)
      w_word = w_back ^ w_sub;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_nk        <= 4'd4;
      r_nkm1      <= 3'd3;
      r_nr        <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_rcon      <= RCON_INIT;
      r_win       <= '0;
      r_acc       <= '0;
      r_acnt      <= '0;
      r_rnd       <= '0;
      r_rk_data   <= '0;
      r_rk_idx    <= '0;
      r_rk_last   <= 1'b0;
      r_rk_valid  <= 1'b0;
      r_key_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_key_err <= 1'b0;
      if (r_rk_valid && rk_ready)
        r_rk_valid <= 1'b0;
      if (abort) begin
        r_state     <= ST_IDLE;
        r_key_ready <= 1'b1;
        r_busy      <= 1'b0;
        r_rk_valid  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_load) begin
              r_state     <= ST_EXPAND;
              r_key_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_key       <= key_in;
              r_nk        <= nk_of(key_size);
              r_nkm1      <= 3'(nk_of(key_size) - 4'd1);
              r_nr        <= nr_of(key_size);
              r_i         <= '0;
              r_j         <= '0;
              r_rcon      <= RCON_INIT;
              r_acnt      <= '0;
              r_rnd       <= '0;
            end else if (key_valid) begin
              r_key_err <= 1'b1;
            end
          end
          ST_EXPAND: begin
            if (w_gen) begin
              r_win  <= {r_win[6:0], w_word};
              r_key  <= r_key << 32;
              r_acc  <= {r_acc[63:0], w_word};
              r_acnt <= r_acnt + 2'd1;
              r_i    <= r_i + 6'd1;
              r_j    <= (r_j == r_nkm1) ? 3'd0 : r_j + 3'd1;
              if (!w_key_phase && r_j == 3'd0)
                r_rcon <= xtime(r_rcon);
              if (w_xfer) begin
                r_rk_data  <= {r_acc, w_word};
                r_rk_idx   <= r_rnd;
                r_rk_last  <= (r_rnd == r_nr);
                r_rk_valid <= 1'b1;
                r_rnd      <= r_rnd + 4'd1;
              end
              // 4*(Nr+1)-1 == {Nr, 2'b11}
              if (r_i == {r_nr, 2'b11})
                r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_rk_valid && rk_ready) begin
              r_state     <= ST_IDLE;
              r_key_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_ready = r_key_ready;
  assign busy      = r_busy;
  assign key_err   = r_key_err;
  assign rk_data   = r_rk_data;
  assign rk_idx    = r_rk_idx;
  assign rk_last   = r_rk_last;
  assign rk_valid  = r_rk_valid;

`ifdef AES_ROUNDKEY_STORE_EN
  logic [14:0][127:0] r_store;
  logic [127:0]       r_rd_data;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_store   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_load)
        r_store <= '0;
      else if (w_xfer && !abort)
        r_store[r_rnd] <= {r_acc, w_word};
      r_rd_data <= (rd_idx <= r_nr && rd_idx != 4'd15) ? r_store[rd_idx] : '0;
    end
  end

  assign rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_idx;
  assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_aes_key_expander_stream.sv
// Scoreboarded bench: an independent FIPS-197 schedule model fills a queue of expected beats.
module tb_aes_key_expander_stream;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic [255:0] key_in = '0;
  logic [1:0]   key_size = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         abort = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         busy;
  logic         key_err;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_data;

  logic [127:0] key_in2 = '0;
  logic [1:0]   key_size2 = '0;
  logic         key_valid2 = 1'b0;
  logic         key_ready2;
  logic         abort2 = 1'b0;
  logic [127:0] rk_data2;
  logic [3:0]   rk_idx2;
  logic         rk_last2;
  logic         rk_valid2;
  logic         rk_ready2 = 1'b1;
  logic         busy2;
  logic         key_err2;
  logic [3:0]   rd_idx2 = '0;
  logic [127:0] rd_data2;

  int n_chk = 0;
  int n_pass = 0;
  beat_t q[$];
  logic [7:0]   sb [0:255];
  logic [31:0]  ew [0:59];
  logic [127:0] got_rk [0:15];

  localparam logic [255:0] K_FIPS128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K_SEQ128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K_SEQ192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K_SEQ256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_key_expander_stream #(.MAX_KEY_BITS(256), .WORDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_(rst_), .key_in(key_in), .key_size(key_size), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .rk_data(rk_data), .rk_idx(rk_idx),
    .rk_last(rk_last), .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy),
    .key_err(key_err), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  aes_key_expander_stream #(.MAX_KEY_BITS(128), .WORDS_PER_CYCLE(1)) u_dut128 (
    .clk(clk), .rst_(rst_), .key_in(key_in2), .key_size(key_size2), .key_valid(key_valid2),
    .key_ready(key_ready2), .abort(abort2), .rk_data(rk_data2), .rk_idx(rk_idx2),
    .rk_last(rk_last2), .rk_valid(rk_valid2), .rk_ready(rk_ready2), .busy(busy2),
    .key_err(key_err2), .rd_idx(rd_idx2), .rd_data(rd_data2)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine map, built independently of the design table.
  task automatic init_sbox;
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) ew[i] = key[255 - 32*i -: 32];
      else begin
        t = ew[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        ew[i] = ew[i-nk] ^ t;
      end
    end
  endtask

  task automatic run_key(input logic [255:0] key, input logic [1:0] ks, input bit rnd,
                         input bit timing, input string nm);
    int nk, nr, c, nacc, scnt, tgt;
    bit was_stall, fresh;
    logic [127:0] hd;
    logic [3:0]   hi;
    logic         hl;
    beat_t        e;
    nk = (ks == 2'd0) ? 4 : (ks == 2'd1) ? 6 : 8;
    nr = nk + 6;
    expand(key, nk);
    q.delete();
    for (int r = 0; r <= nr; r++) begin
      e.d = {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
      e.idx = 4'(r);
      e.last = (r == nr);
      q.push_back(e);
    end
    c = 0;
    while (!key_ready && c < 50) begin @(posedge clk); #1; c++; end
    n_chk++;
    if (key_ready !== 1'b1) $display("FAIL %s key_ready: got %b want 1", nm, key_ready);
    else n_pass++;
    key_in = key; key_size = ks; key_valid = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_size = ks + 2'd1; key_in = ~key;
    c = 0; nacc = 0; scnt = 0; was_stall = 0; fresh = 1;
    tgt = rnd ? int'($urandom_range(1, 3)) : 0;
    while (nacc <= nr && c < 1000) begin
      if (was_stall) begin
        n_chk++;
        if (rk_valid !== 1'b1 || rk_data !== hd || rk_idx !== hi || rk_last !== hl)
          $display("FAIL %s stall_stable: got v=%b idx=%0d last=%b data=%h want v=1 idx=%0d last=%b data=%h",
                   nm, rk_valid, rk_idx, rk_last, rk_data, hi, hl, hd);
        else n_pass++;
      end
      was_stall = 0;
      if (rk_valid === 1'b1) begin
        if (fresh && timing) begin
          n_chk++;
          if (c != 4 + 4*nacc) $display("FAIL %s beat_time r%0d: got cycle %0d want %0d", nm, nacc, c, 4 + 4*nacc);
          else n_pass++;
        end
        fresh = 0;
        if (scnt < tgt) begin
          rk_ready = 1'b0; scnt++; was_stall = 1;
          hd = rk_data; hi = rk_idx; hl = rk_last;
        end else begin
          rk_ready = 1'b1;
          e = (q.size() > 0) ? q.pop_front() : '0;
          n_chk++;
          if ({rk_data, rk_idx, rk_last} !== e)
            $display("FAIL %s beat r%0d: got idx=%0d last=%b data=%h want idx=%0d last=%b data=%h",
                     nm, nacc, rk_idx, rk_last, rk_data, e.idx, e.last, e.d);
          else n_pass++;
          got_rk[rk_idx] = rk_data;
          nacc++; scnt = 0; fresh = 1;
          tgt = rnd ? int'($urandom_range(1, 3)) : 0;
        end
      end else begin
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1; c++;
    end
    rk_ready = 1'b1;
    n_chk++;
    if (nacc != nr + 1) $display("FAIL %s beat_count: got %0d want %0d", nm, nacc, nr + 1);
    else n_pass++;
    n_chk++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0)
      $display("FAIL %s done_idle: got ready=%b busy=%b valid=%b want 1 0 0", nm, key_ready, busy, rk_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_chk++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 || key_err !== 1'b0)
      $display("FAIL reset_ctl: got ready=%b busy=%b valid=%b err=%b want 1 0 0 0", key_ready, busy, rk_valid, key_err);
    else n_pass++;
    n_chk++;
    if (rk_data !== '0 || rk_idx !== '0 || rk_last !== 1'b0 || rd_data !== '0)
      $display("FAIL reset_data: got data=%h idx=%0d last=%b rd=%h want zeros", rk_data, rk_idx, rk_last, rd_data);
    else n_pass++;
    n_chk++;
    if (key_ready2 !== 1'b1 || busy2 !== 1'b0 || rk_valid2 !== 1'b0 || key_err2 !== 1'b0 ||
        rk_data2 !== '0 || rk_idx2 !== '0 || rk_last2 !== 1'b0 || rd_data2 !== '0)
      $display("FAIL reset_dut128: got ready=%b busy=%b valid=%b err=%b data=%h want 1 0 0 0 0",
               key_ready2, busy2, rk_valid2, key_err2, rk_data2);
    else n_pass++;
    @(negedge clk); rst_ = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_aes128_fips;
    run_key(K_FIPS128, 2'd0, 1'b0, 1'b1, "aes128_fips");
    n_chk++;
    if (got_rk[0] !== K_FIPS128[255:128]) $display("FAIL fips_r0: got %h want %h", got_rk[0], K_FIPS128[255:128]);
    else n_pass++;
    n_chk++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
      $display("FAIL fips_r1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
    else n_pass++;
    n_chk++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL fips_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
    else n_pass++;
  endtask

  task automatic test_aes128_seq;
    run_key(K_SEQ128, 2'd0, 1'b0, 1'b1, "aes128_seq");
    n_chk++;
    if (got_rk[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      $display("FAIL seq128_r10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", got_rk[10]);
    else n_pass++;
  endtask

  task automatic test_aes192;
    run_key(K_SEQ192, 2'd1, 1'b0, 1'b1, "aes192");
    n_chk++;
    if (got_rk[12] !== 128'ha4970a331a78dc09c418c271e3a41d5d)
      $display("FAIL seq192_r12: got %h want a4970a331a78dc09c418c271e3a41d5d", got_rk[12]);
    else n_pass++;
  endtask

  task automatic test_aes256_stall;
    run_key(K_SEQ256, 2'd2, 1'b1, 1'b0, "aes256_stall");
    n_chk++;
    if (got_rk[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36)
      $display("FAIL seq256_r14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", got_rk[14]);
    else n_pass++;
  endtask

  task automatic test_key_err;
    bit seen;
    int c;
    key_in = K_SEQ256; key_size = 2'd3; key_valid = 1'b1;
    key_in2 = K_SEQ128[255:128]; key_size2 = 2'd2; key_valid2 = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_valid2 = 1'b0;
    n_chk++;
    if (key_err !== 1'b1 || busy !== 1'b0 || key_ready !== 1'b1)
      $display("FAIL key_err_rsvd: got err=%b busy=%b ready=%b want 1 0 1", key_err, busy, key_ready);
    else n_pass++;
    n_chk++;
    if (key_err2 !== 1'b1 || busy2 !== 1'b0 || key_ready2 !== 1'b1)
      $display("FAIL key_err_max128: got err=%b busy=%b ready=%b want 1 0 1", key_err2, busy2, key_ready2);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (key_err !== 1'b0 || key_err2 !== 1'b0)
      $display("FAIL key_err_pulse: got err=%b err128=%b want 0 0", key_err, key_err2);
    else n_pass++;
    seen = 0;
    repeat (8) begin
      if (rk_valid || busy || rk_valid2 || busy2) seen = 1;
      @(posedge clk); #1;
    end
    n_chk++;
    if (seen) $display("FAIL key_err_silent: got output activity want none");
    else n_pass++;
    // A supported size on the narrow instance still works.
    key_in2 = K_FIPS128[255:128]; key_size2 = 2'd0; key_valid2 = 1'b1;
    @(posedge clk); #1;
    key_valid2 = 1'b0;
    c = 0;
    while (!rk_valid2 && c < 20) begin @(posedge clk); #1; c++; end
    n_chk++;
    if (rk_valid2 !== 1'b1 || c != 4 || rk_data2 !== K_FIPS128[255:128] || rk_idx2 !== 4'd0)
      $display("FAIL dut128_r0: got v=%b cycle=%0d data=%h want 1 4 %h", rk_valid2, c, rk_data2, K_FIPS128[255:128]);
    else n_pass++;
    abort2 = 1'b1;
    @(posedge clk); #1;
    abort2 = 1'b0;
  endtask

  task automatic test_abort_reset;
    int c;
    bit hit;
    rk_ready = 1'b1;
    key_in = K_SEQ128; key_size = 2'd0; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    c = 0; hit = 0;
    while (!hit && c < 100) begin
      if (rk_valid && rk_idx == 4'd5) hit = 1;
      else begin @(posedge clk); #1; c++; end
    end
    n_chk++;
    if (!hit) $display("FAIL abort_reach_r5: got no r5 beat within %0d cycles want r5", c);
    else n_pass++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_chk++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1)
      $display("FAIL abort_idle: got valid=%b busy=%b ready=%b want 0 0 1", rk_valid, busy, key_ready);
    else n_pass++;
    key_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; abort = 1'b0;
    hit = 0;
    repeat (6) begin
      if (rk_valid || busy) hit = 1;
      @(posedge clk); #1;
    end
    n_chk++;
    if (hit) $display("FAIL abort_beats_offer: got key accepted want rejected");
    else n_pass++;
    key_in = K_SEQ256; key_size = 2'd2; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    c = 0; hit = 0;
    while (!hit && c < 100) begin
      if (rk_valid && rk_idx == 4'd2) hit = 1;
      else begin @(posedge clk); #1; c++; end
    end
    n_chk++;
    if (!hit) $display("FAIL rst_reach_r2: got no r2 beat within %0d cycles want r2", c);
    else n_pass++;
    #1 rst_ = 1'b1;
    #1;
    n_chk++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_data !== '0)
      $display("FAIL rst_midrun: got valid=%b busy=%b ready=%b data=%h want 0 0 1 0", rk_valid, busy, key_ready, rk_data);
    else n_pass++;
    @(posedge clk); #1;
    rst_ = 1'b0;
    @(posedge clk); #1;
    run_key(K_FIPS128, 2'd0, 1'b0, 1'b1, "aes128_after_rst");
    n_chk++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
      $display("FAIL after_rst_r1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    init_sbox();
    test_reset();
    test_aes128_fips();
    test_aes128_seq();
    test_aes192();
    test_aes256_stall();
    test_key_err();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_key_expander_stream.md
Name: aes_key_expander_stream

Overview:
- Iterative AES key-schedule engine; successor to the fixed AES-128, eleven-port key generator.
- Supports 128/192/256-bit keys, selected at run time and bounded by a parameter.
- Generates one 32-bit schedule word per cycle and streams 128-bit round keys over a valid/ready handshake.
- Sits between the input interface (key source) and the round transformer (round-key sink).

Parameters:
- MAX_KEY_BITS, 256: widest supported key. Legal values: 128, 192, 256.
- WORDS_PER_CYCLE, 1: schedule words generated per cycle. Only 1 is legal in this generation; a static assertion fails on any other value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  asynchronous reset, active-high; port name kept per codebase convention despite the polarity.
- key_in  in  MAX_KEY_BITS  cipher key, FIPS-197 byte order. w0 = key_in[MAX_KEY_BITS-1 -: 32]; shorter keys are MSB-aligned.
- key_size  in  2  0=128, 1=192, 2=256, 3=reserved. Sampled with key_in.
- key_valid  in  1  key offer.
- key_ready  out  1  high in IDLE only.
- abort  in  1  synchronous abort.
- rk_data  out  128  round key; w[4r] occupies the MSBs.
- rk_idx  out  4  round number r, 0..Nr.
- rk_last  out  1  high with the final round key.
- rk_valid  out  1  round-key output valid.
- rk_ready  in  1  sink accepts.
- busy  out  1  high outside IDLE.
- key_err  out  1  one-cycle pulse on an unsupported key_size.
- rd_idx  in  4  store read index (optional feature).
- rd_data  out  128  store read data (optional feature).

Behaviour:
- Reset values: every output 0 except key_ready=1. Reset clears all state including the output register; it takes effect immediately, mid-operation included.
- Key sizes: Nk = 4/6/8; Nr = Nk+6; total schedule words = 4*(Nr+1) = 44/52/60.
- FSM states: IDLE, EXPAND, DRAIN.
- IDLE:
  - On key_valid&&key_ready: latch key and key_size; word counter i=0; rcon=0x01.
  - If key_size is 3, or exceeds MAX_KEY_BITS: pulse key_err next cycle, stay in IDLE, emit nothing.
  - Otherwise go to EXPAND.
- EXPAND, one word w[i] per cycle:
  - i<Nk: w[i] = key word i.
  - i%Nk==0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. shift left, reduce with 0x1B on carry out.
  - Nk==8 && i%8==4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - History is an Nk-deep sliding window of words, not the full schedule.
- Round assembly:
  - Each word shifts into a 4-word accumulator.
  - On the 4th word, the accumulator transfers to rk_data/rk_idx and rk_valid is set.
  - If rk_valid && !rk_ready would block that transfer, generation stalls; no word is lost and i does not advance.
- Latency and throughput: first rk_valid is 4 cycles after the key-accept edge. Sustained rate is one round key per 4 cycles with rk_ready held high.
- rk_data, rk_idx and rk_last are stable while rk_valid && !rk_ready.
- DRAIN: entered after the last word. Returns to IDLE once the round-key-Nr beat is accepted; key_ready rises the following cycle.
- abort: forces IDLE from any state and drops rk_valid the next cycle. If abort and a key offer occur in the same cycle, abort wins and the key is not accepted.
- Boundary conditions:
  - The rk_ready stall is tested at every round, including r=0 and r=Nr.
  - i wraps never; the counter width is 6 bits and its maximum value is 59.
  - key_size changes while busy are ignored.

Optional Feature:
- AES_ROUNDKEY_STORE_EN defined:
  - Each emitted round key is also written into a 15x128 register file at rk_idx.
  - rd_data = store[rd_idx], registered, 1-cycle latency.
  - rd_idx > Nr of the last key returns 0.
  - The store clears on reset and on key accept.
- Undefined: no store; rd_data tied 0; rd_idx ignored.

Decomposition:
- Shared package/include (aes_pkg), containing:
  - key-size encodings
  - NK/NR lookup constants
  - RCON_INIT = 8'h01
  - xtime reduction constant 8'h1B
  - FSM state encodings
- Sub-module aes_sbox_word: four combinational S-box byte lookups for SubWord. Shared later by the round transformer.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> r0 = key; r1 = a0fafe1788542cb123a339392a6c7605 at accept+8; 11 beats; rk_last on r10.
- AES-128, key 000102...0f -> r10 = 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192, key 000102...17 -> 13 beats; r12 = a4970a331a78dc09c418c271e3a41d5d.
- AES-256, key 000102...1f, rk_ready randomly toggled -> 15 beats; r14 = 24fc79ccbf0979e9371ac23c6d68de36; outputs stable during every stall.
- key_size=3 -> key_err one cycle, no rk_valid. With MAX_KEY_BITS=128, key_size=2 -> same response.
- abort at r5, then rst_ pulsed at r2 of a new key -> IDLE and rk_valid=0 in both cases. A subsequent AES-128 key then reproduces the correct r1.
